// File: rtl/ble_cmd_auth.sv
// ble_cmd_auth: 8N1 receiver for BLE command bytes feeding a G/S power-authorisation FSM.
// Define BLE_LINK_TIMEOUT_EN to add a link-loss timer that forces a pending stop while powered.
module ble_cmd_auth #(
    parameter int unsigned BAUD_DIV    = 2604,
    parameter logic [7:0]  GO_CODE     = 8'h47,
    parameter logic [7:0]  STOP_CODE   = 8'h53,
    parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    output logic       frm_err
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
    // The counter spends N+1 cycles from a load of N down to 0, so loads are one short.
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HI
    } rx_state_t;

    typedef enum logic [1:0] {
        A_OFF,
        A_PWR1,
        A_PWR2
    } auth_state_t;

    logic             rx_meta_q, rx_s_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_rdy_q, rx_rdy_d;
    logic             frm_err_q, frm_err_d;
    logic [7:0]       rx_data_q, rx_data_d;
    auth_state_t      auth_q, auth_d;
    logic             pwr_up_q, pwr_up_d;
    logic             baud_exp;
    logic             link_lost;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    assign baud_exp = (baud_cnt_q == '0);

    always_comb begin
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        if ((rx_state_q == RX_START || rx_state_q == RX_DATA || rx_state_q == RX_STOP) && !baud_exp)
            baud_cnt_d = baud_cnt_q - 1'b1;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    baud_cnt_d = HALF_LD;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (baud_exp) begin
                    if (rx_s_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        baud_cnt_d = FULL_LD;
                        bit_cnt_d  = '0;
                        rx_state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (baud_exp) begin
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    baud_cnt_d = FULL_LD;
                    if (bit_cnt_q == 3'd7)
                        rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_exp)
                    rx_state_d = rx_s_q ? RX_IDLE : RX_WAIT_HI;
            end
            // A held-low line (break) must go high before another start bit is accepted.
            RX_WAIT_HI: begin
                if (rx_s_q)
                    rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_rdy_d  = 1'b0;
        frm_err_d = 1'b0;
        rx_data_d = rx_data_q;
        if (rx_state_q == RX_STOP && baud_exp) begin
            if (rx_s_q) begin
                rx_rdy_d  = 1'b1;
                rx_data_d = shift_q;
            end else begin
                frm_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_rdy_q  <= 1'b0;
            frm_err_q <= 1'b0;
            rx_data_q <= 8'h00;
        end else begin
            rx_rdy_q  <= rx_rdy_d;
            frm_err_q <= frm_err_d;
            rx_data_q <= rx_data_d;
        end
    end

`ifdef BLE_LINK_TIMEOUT_EN
    localparam int unsigned     TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || rx_rdy_q || auth_q == A_OFF)
            to_cnt_q <= '0;
        else if (to_cnt_q != TO_MAX)
            to_cnt_q <= to_cnt_q + 1'b1;
    end

    assign link_lost = (auth_q == A_PWR1) && (to_cnt_q == TO_MAX);
`else
    assign link_lost = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            auth_q <= A_OFF;
        else
            auth_q <= auth_d;
    end

    always_comb begin
        auth_d = auth_q;
        case (auth_q)
            A_OFF: begin
                if (rx_rdy_q && rx_data_q == GO_CODE)
                    auth_d = A_PWR1;
            end
            A_PWR1: begin
                if (rx_rdy_q && rx_data_q == STOP_CODE)
                    auth_d = rider_off ? A_OFF : A_PWR2;
                else if (link_lost && !rx_rdy_q)
                    auth_d = A_PWR2;
            end
            // A fresh GO beats a rider stepping off in the same cycle.
            A_PWR2: begin
                if (rx_rdy_q && rx_data_q == GO_CODE)
                    auth_d = A_PWR1;
                else if (rider_off)
                    auth_d = A_OFF;
            end
            default: auth_d = A_OFF;
        endcase
    end

    always_comb begin
        pwr_up_d = (auth_d != A_OFF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pwr_up_q <= 1'b0;
        else
            pwr_up_q <= pwr_up_d;
    end

    assign pwr_up  = pwr_up_q;
    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_data_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_ble_cmd_auth.sv
// Bench for ble_cmd_auth: directed scenarios plus random command streams against a power model.
module tb_ble_cmd_auth;
    localparam int BD = 16;
    localparam int TO = 1000;
    localparam logic [7:0] G = 8'h47;
    localparam logic [7:0] S = 8'h53;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic       pwr_up, rx_rdy, frm_err;
    logic [7:0] rx_data;

    int checks = 0;
    int failures = 0;

    int         cyc = 0;
    int         rdy_cnt = 0;
    int         ferr_cnt = 0;
    int         rdy_cyc = 0;
    int         frame_cyc = 0;
    logic [7:0] rdy_byte = 8'h00;
    logic [7:0] rdy_log[$];
    logic       pwr_at_rdy = 1'b0;
    logic       pwr_post_rdy = 1'b0;
    bit         post_pending = 0;
    bit         arm_rider = 0;

    // Model: powered, and whether a stop is waiting for the rider to step off.
    bit         m_pwr = 0;
    bit         m_stop = 0;

    ble_cmd_auth #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .rider_off(rider_off),
        .pwr_up   (pwr_up),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (post_pending) begin
            pwr_post_rdy = pwr_up;
            post_pending = 0;
        end
        if (rx_rdy) begin
            rdy_cnt++;
            rdy_byte = rx_data;
            rdy_log.push_back(rx_data);
            rdy_cyc = cyc;
            pwr_at_rdy = pwr_up;
            post_pending = 1;
        end
        if (frm_err) ferr_cnt++;
    end

    function automatic void model_rider();
        if (m_stop && rider_off) begin
            m_pwr = 0;
            m_stop = 0;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == G) begin
            m_pwr = 1;
            m_stop = 0;
        end else if (b == S && m_pwr && !m_stop) begin
            if (rider_off) m_pwr = 0;
            else m_stop = 1;
        end
        model_rider();
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (arm_rider && rx_rdy) begin
                rider_off = 1'b1;
                arm_rider = 0;
            end
        end
    endtask

    task automatic bit_out(input logic v, input int n);
        RX = v;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        frame_cyc = cyc;
        bit_out(1'b0, BD);
        for (int i = 0; i < 8; i++) bit_out(b[i], BD);
        bit_out(stop, stop_len);
        RX = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL reset_pwr_up: got %b want 0", pwr_up); end
        checks++; if (rx_rdy !== 1'b0) begin failures++; $display("FAIL reset_rx_rdy: got %b want 0", rx_rdy); end
        checks++; if (frm_err !== 1'b0) begin failures++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        rst_n = 1'b1;
        m_pwr = 0; m_stop = 0;
        tick(4);
    endtask

    task automatic test_basic();
        int r0;
        rider_off = 1'b0;
        r0 = rdy_cnt;
        send_frame(G, 1'b1, BD);
        model_byte(G);
        checks++; if (rdy_cnt !== r0 + 1) begin failures++; $display("FAIL basic_g_rdy: got %0d pulses want 1", rdy_cnt - r0); end
        checks++; if (rx_data !== G) begin failures++; $display("FAIL basic_g_data: got %h want %h", rx_data, G); end
        checks++; if (rdy_cyc - frame_cyc < 152 || rdy_cyc - frame_cyc > 156) begin
            failures++; $display("FAIL basic_latency: got %0d cycles want 152..156", rdy_cyc - frame_cyc); end
        checks++; if (pwr_at_rdy !== 1'b0 || pwr_post_rdy !== 1'b1) begin
            failures++; $display("FAIL basic_pwr_edge: got %b->%b want 0->1", pwr_at_rdy, pwr_post_rdy); end
        send_frame(S, 1'b1, BD);
        model_byte(S);
        checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL basic_pwr2_hold: got %b want 1", pwr_up); end
        rider_off = 1'b1;
        tick(1);
        model_rider();
        checks++; if (pwr_up !== m_pwr) begin failures++; $display("FAIL basic_rider_drop: got %b want %b", pwr_up, m_pwr); end
        tick(2);
    endtask

    task automatic test_stop_rider_off();
        int r0;
        rider_off = 1'b0;
        send_frame(G, 1'b1, BD);
        model_byte(G);
        rider_off = 1'b1;
        tick(3);
        model_rider();
        checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL pwr1_ignores_rider: got %b want 1", pwr_up); end
        send_frame(S, 1'b1, BD);
        model_byte(S);
        checks++; if (pwr_at_rdy !== 1'b1 || pwr_post_rdy !== m_pwr) begin
            failures++; $display("FAIL stop_off_edge: got %b->%b want 1->%b", pwr_at_rdy, pwr_post_rdy, m_pwr); end
        r0 = rdy_cnt;
        send_frame(8'h41, 1'b1, BD);
        model_byte(8'h41);
        checks++; if (rdy_cnt !== r0 + 1 || rdy_byte !== 8'h41) begin
            failures++; $display("FAIL other_byte_rdy: got %0d pulses byte %h want 1 pulse 41", rdy_cnt - r0, rdy_byte); end
        checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL other_byte_pwr: got %b want 0", pwr_up); end
        rider_off = 1'b0;
        tick(2);
    endtask

    task automatic test_frame_error();
        int r0, f0;
        r0 = rdy_cnt; f0 = ferr_cnt;
        send_frame(G, 1'b0, 5 * BD);
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL ferr_pulse: got %0d pulses want 1", ferr_cnt - f0); end
        checks++; if (rdy_cnt !== r0) begin failures++; $display("FAIL ferr_no_rdy: got %0d pulses want 0", rdy_cnt - r0); end
        checks++; if (rx_data !== 8'h41) begin failures++; $display("FAIL ferr_data_held: got %h want 41", rx_data); end
        checks++; if (pwr_up !== 1'b0) begin failures++; $display("FAIL ferr_pwr: got %b want 0", pwr_up); end
        tick(12 * BD);
        checks++; if (rdy_cnt !== r0 || ferr_cnt !== f0 + 1) begin
            failures++; $display("FAIL ferr_no_restart: got rdy %0d ferr %0d want 0 and 1", rdy_cnt - r0, ferr_cnt - f0); end
    endtask

    task automatic test_glitch_and_reset();
        int r0, f0;
        r0 = rdy_cnt; f0 = ferr_cnt;
        RX = 1'b0;
        tick(3);
        RX = 1'b1;
        tick(12 * BD);
        checks++; if (rdy_cnt !== r0 || ferr_cnt !== f0) begin
            failures++; $display("FAIL glitch: got rdy %0d ferr %0d want 0 and 0", rdy_cnt - r0, ferr_cnt - f0); end
        send_frame(G, 1'b1, BD);
        model_byte(G);
        r0 = rdy_cnt; f0 = ferr_cnt;
        frame_cyc = cyc;
        bit_out(1'b0, BD);
        for (int i = 0; i < 4; i++) bit_out(G[i], BD);
        bit_out(G[4], BD / 2);
        rst_n = 1'b0;
        tick(1);
        m_pwr = 0; m_stop = 0;
        checks++; if (pwr_up !== 1'b0 || rx_rdy !== 1'b0 || frm_err !== 1'b0 || rx_data !== 8'h00) begin
            failures++; $display("FAIL midframe_reset: got pwr %b rdy %b ferr %b data %h want 0 0 0 00", pwr_up, rx_rdy, frm_err, rx_data); end
        RX = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(12 * BD);
        checks++; if (rdy_cnt !== r0 || ferr_cnt !== f0) begin
            failures++; $display("FAIL midframe_no_strobe: got rdy %0d ferr %0d want 0 and 0", rdy_cnt - r0, ferr_cnt - f0); end
        send_frame(G, 1'b1, BD);
        model_byte(G);
        checks++; if (rdy_cnt !== r0 + 1 || rx_data !== G || pwr_up !== m_pwr) begin
            failures++; $display("FAIL after_reset_g: got rdy %0d data %h pwr %b want 1 47 %b", rdy_cnt - r0, rx_data, pwr_up, m_pwr); end
    endtask

    task automatic test_simultaneous();
        rider_off = 1'b0;
        send_frame(S, 1'b1, BD);
        model_byte(S);
        arm_rider = 1;
        send_frame(G, 1'b1, BD);
        checks++; if (arm_rider !== 0) begin failures++; $display("FAIL simul_no_rdy: rx_rdy never seen within frame"); arm_rider = 0; end
        model_byte(G);
        tick(4);
        model_rider();
        checks++; if (pwr_up !== m_pwr || rider_off !== 1'b1) begin
            failures++; $display("FAIL simul_go_wins: got pwr %b rider %b want %b 1", pwr_up, rider_off, m_pwr); end
        rider_off = 1'b0;
        tick(2);
    endtask

    task automatic test_back_to_back();
        int r0;
        rider_off = 1'b0;
        send_frame(G, 1'b1, BD);
        model_byte(G);
        r0 = rdy_cnt;
        send_frame(S, 1'b1, BD / 2 + 4);
        model_byte(S);
        send_frame(G, 1'b1, BD);
        model_byte(G);
        checks++; if (rdy_cnt !== r0 + 2) begin failures++; $display("FAIL b2b_count: got %0d pulses want 2", rdy_cnt - r0); end
        else begin
            checks++; if (rdy_log[rdy_log.size() - 2] !== S || rdy_log[rdy_log.size() - 1] !== G) begin
                failures++; $display("FAIL b2b_bytes: got %h %h want 53 47", rdy_log[rdy_log.size() - 2], rdy_log[rdy_log.size() - 1]); end
        end
        checks++; if (pwr_up !== m_pwr) begin failures++; $display("FAIL b2b_pwr: got %b want %b", pwr_up, m_pwr); end
    endtask

    task automatic test_random();
        int r0;
        logic [7:0] b;
        for (int n = 0; n < 20; n++) begin
            rider_off = 1'($urandom_range(0, 1));
            tick(3);
            model_rider();
            checks++; if (pwr_up !== m_pwr) begin failures++; $display("FAIL rand_rider[%0d]: got pwr %b want %b", n, pwr_up, m_pwr); end
            case ($urandom_range(0, 4))
                0, 1: b = G;
                2, 3: b = S;
                default: b = 8'($urandom);
            endcase
            r0 = rdy_cnt;
            send_frame(b, 1'b1, BD);
            model_byte(b);
            checks++; if (rdy_cnt !== r0 + 1 || rdy_byte !== b) begin
                failures++; $display("FAIL rand_rx[%0d]: got %0d pulses byte %h want 1 pulse %h", n, rdy_cnt - r0, rdy_byte, b); end
            checks++; if (pwr_up !== m_pwr) begin failures++; $display("FAIL rand_pwr[%0d]: byte %h got %b want %b", n, b, pwr_up, m_pwr); end
        end
        rider_off = 1'b0;
        tick(2);
    endtask

    task automatic test_timeout();
        rider_off = 1'b0;
        send_frame(G, 1'b1, BD);
        model_byte(G);
        tick(TO + 100);
`ifdef BLE_LINK_TIMEOUT_EN
        m_stop = 1;
`endif
        checks++; if (pwr_up !== 1'b1) begin failures++; $display("FAIL timeout_hold: got %b want 1", pwr_up); end
        rider_off = 1'b1;
        tick(2);
        model_rider();
        checks++; if (pwr_up !== m_pwr) begin failures++; $display("FAIL timeout_rider: got %b want %b", pwr_up, m_pwr); end
        tick(TO);
        checks++; if (pwr_up !== m_pwr) begin failures++; $display("FAIL timeout_late: got %b want %b", pwr_up, m_pwr); end
        rider_off = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stop_rider_off();
        test_frame_error();
        test_glitch_and_reset();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
